grid_arbiter: RTL

Shares the single-ported level grid memory between up to NUM_REQ requester blocks: the enemy updater, the player updater and the renderer. Each requester raises a request, waits for a registered grant, owns the grid address/write bus exclusively until it drops its request, then releases it. Ownership is rotated round-robin, and unowned cycles can never write the grid. A sticky watchdog flags any requester that holds the bus too long.

---
 rtl/grid_pkg.sv | 26 ++
 rtl/grid_arbiter_rr_picker.sv | 38 +++
 rtl/grid_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// =============================================================================
// Module      : grid_pkg
// Description : Shared grid geometry, cell codes and requester indices.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package grid_pkg;

    localparam int X_W    = 6;
    localparam int Y_W    = 5;
    localparam int CELL_W = 3;

    localparam logic [CELL_W-1:0] CELL_AIR   = 3'd0;
    localparam logic [CELL_W-1:0] CELL_ENEMY = 3'd4;

    localparam int GRID_X_MAX = 39;
    localparam int GRID_Y_MAX = 29;

    localparam int REQ_ENEMY  = 0;
    localparam int REQ_PLAYER = 1;
    localparam int REQ_RENDER = 2;

endpackage

`default_nettype wire

// File: rtl/grid_arbiter_rr_picker.sv
// =============================================================================
// Module      : rr_picker
// Description : Combinational round-robin pick: first set request at or after ptr.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic found;
    int   idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/grid_arbiter.sv
// =============================================================================
// Module      : grid_arbiter
// Description : Round-robin owner of the single-ported grid bus with hold watchdog.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module grid_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = grid_pkg::X_W,
    parameter int Y_W      = grid_pkg::Y_W,
    parameter int CELL_W   = grid_pkg::CELL_W,
    parameter int MAX_HOLD = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*CELL_W-1:0]  req_in,
    output logic [X_W-1:0]             grid_x,
    output logic [Y_W-1:0]             grid_y,
    output logic                       grid_write,
    output logic [CELL_W-1:0]          grid_in,
    output logic                       hold_timeout,
    output logic [1:0]                 timeout_id
);

    import grid_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]         state;
    logic [0:0]         next_state;
    logic [NUM_REQ-1:0] next_grant;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   owner;
    logic               owner_req;
    logic [CNT_W-1:0]   hold_cnt;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner = PTR_W'(i);
        end
    end

    assign owner_req = |(req & grant);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= next_state;
            grant <= next_grant;
            ptr   <= next_ptr;
        end
    end

    // The pointer moves only on release, so a waiting requester always wins next.
    always_comb begin
        next_state = state;
        next_grant = grant;
        next_ptr   = ptr;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    next_grant = pick;
                    next_state = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    next_grant = '0;
                    next_state = ST_IDLE;
                    if (owner == PTR_W'(NUM_REQ - 1)) next_ptr = '0;
                    else                              next_ptr = owner + 1'b1;
                end
            end
            default: begin
                next_grant = '0;
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        grid_x = '0;
        grid_y = '0;
        grid_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grid_x  = req_x[i*X_W +: X_W];
                grid_y  = req_y[i*Y_W +: Y_W];
                grid_in = req_in[i*CELL_W +: CELL_W];
            end
        end
        // Masking with req kills the write in the release cycle.
        grid_write = (state == ST_OWNED) && (|(grant & req & req_write));
    end

    // hold_cnt counts completed OWNED cycles; the flag sets on the edge it reaches MAX_HOLD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
            timeout_id   <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (pick_valid) hold_cnt <= '0;
            end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if ((state == ST_OWNED) && (hold_cnt == CNT_W'(MAX_HOLD - 1)) && !hold_timeout) begin
                hold_timeout <= 1'b1;
                timeout_id   <= 2'(owner);
            end
        end
    end

endmodule

`default_nettype wire
